// File: rtl/err_inj_pkg.sv
// Shared definitions for the error-injection tree: sequencer state encoding
// and the default widths the splitters decode against.
package err_inj_pkg;

    localparam int CTRLW  = 8;
    localparam int DWELLW = 16;
    localparam int GAPW   = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INJECT = 2'd1,
        ST_GAP    = 2'd2
    } seq_state_e;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/err_ctrl_sequencer_if.sv
// Host-side control/status bundle of the error-injection sequencer, including
// the err_en/err_ctrl bus that fans out to the splitters.
interface err_ctrl_sequencer_if #(
    parameter int CTRLW  = err_inj_pkg::CTRLW,
    parameter int DWELLW = err_inj_pkg::DWELLW,
    parameter int GAPW   = err_inj_pkg::GAPW
);
    import err_inj_pkg::*;

    logic [CTRLW-1:0]  cfg_start_code;
    logic [CTRLW-1:0]  cfg_end_code;
    logic [DWELLW-1:0] cfg_dwell;
    logic [GAPW-1:0]   cfg_gap;
    logic              cfg_loop;
    logic              start;
    logic              abort;
    logic              hold;
    logic              busy;
    logic              done;
    logic              cfg_err;
    logic              err_en;
    logic [CTRLW-1:0]  err_ctrl;

    modport master (
        output cfg_start_code, cfg_end_code, cfg_dwell, cfg_gap, cfg_loop,
        output start, abort, hold,
        input  busy, done, cfg_err, err_en, err_ctrl
    );

    modport slave (
        input  cfg_start_code, cfg_end_code, cfg_dwell, cfg_gap, cfg_loop,
        input  start, abort, hold,
        output busy, done, cfg_err, err_en, err_ctrl
    );

endinterface

// File: rtl/err_dwell_counter.sv
// Loadable down-counter timing both the per-code dwell and the inter-code gap.
// Load wins over enable; the count saturates at zero.
module err_dwell_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         last
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign last = (count <= W'(1));

endmodule

// File: rtl/err_ctrl_sequencer.sv
// Error-injection campaign sequencer: walks err_ctrl over a shadowed code range,
// holding err_en for a dwell per code with optional idle gaps and looping.
module err_ctrl_sequencer #(
    parameter int CTRLW  = err_inj_pkg::CTRLW,
    parameter int DWELLW = err_inj_pkg::DWELLW,
    parameter int GAPW   = err_inj_pkg::GAPW
) (
    input logic                 clk,
    input logic                 rst_n,
    err_ctrl_sequencer_if.slave bus
);
    import err_inj_pkg::*;

    localparam int CNTW = max_w(DWELLW, GAPW);

    seq_state_e       state;
    logic [CTRLW-1:0] code;
    logic             busy_r, done_r, cfg_err_r, err_en_r;

    logic [CTRLW-1:0] start_sh, end_sh;
    logic [CNTW-1:0]  dwell_sh, gap_sh;
    logic             loop_sh;

    logic             accept, launch, reject, expire, at_end;
    logic [CTRLW-1:0] next_code;
    logic [CNTW-1:0]  cfg_dwell1, load_val;
    logic             cnt_load, cnt_en, cnt_last;

    always_comb begin
        cfg_dwell1 = CNTW'(bus.cfg_dwell);
        if (bus.cfg_dwell == '0) cfg_dwell1 = CNTW'(1);

        accept    = (state == ST_IDLE) && bus.start && !bus.abort;
        launch    = accept && (bus.cfg_start_code <= bus.cfg_end_code);
        reject    = accept && (bus.cfg_start_code >  bus.cfg_end_code);
        expire    = (state != ST_IDLE) && !bus.abort && !bus.hold && cnt_last;
        // Compare before incrementing so an end code of all-ones never wraps.
        at_end    = (code == end_sh);
        next_code = at_end ? start_sh : code + CTRLW'(1);

        cnt_en   = (state != ST_IDLE) && !bus.hold;
        cnt_load = 1'b0;
        load_val = dwell_sh;
        if (launch) begin
            cnt_load = 1'b1;
            load_val = cfg_dwell1;
        end else if (expire) begin
            cnt_load = 1'b1;
            if ((state == ST_INJECT) && (gap_sh != '0) && (!at_end || loop_sh))
                load_val = gap_sh;
        end
    end

    err_dwell_counter #(.W(CNTW)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (load_val),
        .en       (cnt_en),
        .last     (cnt_last)
    );

    // Shadow configuration is plain data, captured only on an accepted start.
    always_ff @(posedge clk) begin
        if (accept) begin
            start_sh <= bus.cfg_start_code;
            end_sh   <= bus.cfg_end_code;
            dwell_sh <= cfg_dwell1;
            gap_sh   <= CNTW'(bus.cfg_gap);
            loop_sh  <= bus.cfg_loop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            code      <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            cfg_err_r <= 1'b0;
            err_en_r  <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            cfg_err_r <= 1'b0;
            if (bus.abort) begin
                state    <= ST_IDLE;
                busy_r   <= 1'b0;
                err_en_r <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (launch) begin
                            state    <= ST_INJECT;
                            busy_r   <= 1'b1;
                            err_en_r <= 1'b1;
                            code     <= bus.cfg_start_code;
                        end else if (reject) begin
                            cfg_err_r <= 1'b1;
                        end
                    end
                    ST_INJECT: begin
                        if (bus.hold) begin
                            err_en_r <= 1'b0;
                        end else if (cnt_last) begin
                            if (at_end && !loop_sh) begin
                                state    <= ST_IDLE;
                                busy_r   <= 1'b0;
                                err_en_r <= 1'b0;
                                done_r   <= 1'b1;
                            end else if (gap_sh != '0) begin
                                state    <= ST_GAP;
                                err_en_r <= 1'b0;
                            end else begin
                                code     <= next_code;
                                err_en_r <= 1'b1;
                            end
                        end else begin
                            err_en_r <= 1'b1;
                        end
                    end
                    ST_GAP: begin
                        if (!bus.hold && cnt_last) begin
                            state    <= ST_INJECT;
                            code     <= next_code;
                            err_en_r <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        busy_r   <= 1'b0;
                        err_en_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.cfg_err  = cfg_err_r;
    assign bus.err_en   = err_en_r;
    assign bus.err_ctrl = code;

endmodule

// File: tb/tb_err_ctrl_sequencer.sv
// Bench for err_ctrl_sequencer: directed and random campaigns compared cycle by
// cycle against a slot-index model derived from the campaign timing rules.
module tb_err_ctrl_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    err_ctrl_sequencer_if bus ();

    err_ctrl_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] prev_code;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic check_outs(input string tag, input logic busy, input logic done,
                              input logic cfg_err, input logic en, input logic [7:0] code);
        check({tag, ".busy"},     32'(bus.busy),     32'(busy));
        check({tag, ".done"},     32'(bus.done),     32'(done));
        check({tag, ".cfg_err"},  32'(bus.cfg_err),  32'(cfg_err));
        check({tag, ".err_en"},   32'(bus.err_en),   32'(en));
        check({tag, ".err_ctrl"}, 32'(bus.err_ctrl), 32'(code));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            bus.start = 1'b0;
            bus.abort = 1'b0;
            bus.hold  = 1'($urandom_range(0, 1));
            tick();
            check_outs(tag, 1'b0, 1'b0, 1'b0, 1'b0, prev_code);
        end
        bus.hold = 1'b0;
    endtask

    // hold_mode: 0 none, 1 random, 2 held during cycles 2 and 3 after launch.
    // abort_at: cycle (after launch) in which abort is driven; 0 means never.
    task automatic run_campaign(input string tag, input int s, input int e, input int d,
                                input int g, input bit lp, input int hold_mode,
                                input int abort_at, input bit noise_start);
        int n, d1, per, total, p, t, m, k, r;
        logic [7:0] c;
        bit en, fin;

        bus.cfg_start_code = 8'(s);
        bus.cfg_end_code   = 8'(e);
        bus.cfg_dwell      = 16'(d);
        bus.cfg_gap        = 16'(g);
        bus.cfg_loop       = lp;
        bus.start          = 1'b1;
        bus.abort          = 1'b0;
        bus.hold           = (hold_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
        bus.start          = 1'b0;
        // Scramble live config: the campaign must run from the captured copy.
        bus.cfg_start_code = 8'($urandom);
        bus.cfg_end_code   = 8'($urandom);
        bus.cfg_dwell      = 16'($urandom);
        bus.cfg_gap        = 16'($urandom);
        bus.cfg_loop       = 1'($urandom);

        if (s > e) begin
            check_outs({tag, ".rej"}, 1'b0, 1'b0, 1'b1, 1'b0, prev_code);
            bus.hold = 1'b0;
            return;
        end

        n     = e - s + 1;
        d1    = (d == 0) ? 1 : d;
        per   = d1 + g;
        total = n * d1 + (n - 1) * g;

        check_outs({tag, ".first"}, 1'b1, 1'b0, 1'b0, 1'b1, 8'(s));
        prev_code = 8'(s);
        p   = 1;
        t   = 1;
        fin = 1'b0;
        while (!fin && t < 2000) begin
            case (hold_mode)
                1:       bus.hold = ($urandom_range(0, 3) == 0);
                2:       bus.hold = (t == 2 || t == 3);
                default: bus.hold = 1'b0;
            endcase
            bus.abort = (t == abort_at);
            bus.start = noise_start && ($urandom_range(0, 3) == 0);
            tick();
            if (bus.abort) begin
                check_outs({tag, ".abort"}, 1'b0, 1'b0, 1'b0, 1'b0, prev_code);
                fin = 1'b1;
            end else if (bus.hold) begin
                check_outs({tag, ".hold"}, 1'b1, 1'b0, 1'b0, 1'b0, prev_code);
            end else if (!lp && p == total) begin
                check_outs({tag, ".done"}, 1'b0, 1'b1, 1'b0, 1'b0, prev_code);
                fin = 1'b1;
            end else begin
                m  = lp ? (p % (n * per)) : p;
                k  = m / per;
                r  = m % per;
                c  = 8'(s + k);
                en = (r < d1);
                check_outs({tag, ".run"}, 1'b1, 1'b0, 1'b0, en, c);
                prev_code = c;
                p++;
            end
            t++;
        end
        if (!fin) check({tag, ".timeout"}, 32'd0, 32'd1);
        bus.hold  = 1'b0;
        bus.abort = 1'b0;
        bus.start = 1'b0;
    endtask

    initial begin
        int s, e, d, g, ab, hm;
        bit lp;

        bus.cfg_start_code = '0;
        bus.cfg_end_code   = '0;
        bus.cfg_dwell      = '0;
        bus.cfg_gap        = '0;
        bus.cfg_loop       = 1'b0;
        bus.start          = 1'b0;
        bus.abort          = 1'b0;
        bus.hold           = 1'b0;
        prev_code          = 8'd0;

        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        rst_n = 1'b1;
        idle_check("idle0", 2);

        run_campaign("basic",  2,   4,   3, 2, 1'b0, 0, 0, 1'b0);
        idle_check("idle1", 1);
        run_campaign("b2b",    254, 255, 0, 0, 1'b0, 0, 0, 1'b1);
        idle_check("idle2", 2);
        run_campaign("reject", 5,   3,   2, 1, 1'b0, 0, 0, 1'b0);
        idle_check("idle3", 1);
        run_campaign("hold",   0,   0,   4, 0, 1'b0, 2, 0, 1'b0);
        idle_check("idle4", 1);
        run_campaign("loop",   1,   2,   1, 0, 1'b1, 0, 7, 1'b1);
        idle_check("idle5", 2);

        // start alongside abort in IDLE must not launch
        bus.cfg_start_code = 8'd3;
        bus.cfg_end_code   = 8'd6;
        bus.cfg_dwell      = 16'd2;
        bus.cfg_gap        = 16'd0;
        bus.cfg_loop       = 1'b0;
        bus.start          = 1'b1;
        bus.abort          = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check_outs("start_abort", 1'b0, 1'b0, 1'b0, 1'b0, prev_code);
        idle_check("idle6", 2);

        // asynchronous reset in the middle of INJECT
        bus.cfg_start_code = 8'd10;
        bus.cfg_end_code   = 8'd12;
        bus.cfg_dwell      = 16'd5;
        bus.start          = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        check_outs("pre_rst", 1'b1, 1'b0, 1'b0, 1'b1, 8'd10);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        rst_n = 1'b1;
        prev_code = 8'd0;
        idle_check("post_rst", 3);
        run_campaign("repulse", 7, 8, 2, 1, 1'b0, 0, 0, 1'b0);
        idle_check("idle7", 1);

        for (int i = 0; i < 40; i++) begin
            s = $urandom_range(0, 250);
            e = s + $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) begin
                s = $urandom_range(252, 255);
                e = 255;
            end
            if ($urandom_range(0, 7) == 0 && s > 0) e = s - 1;
            d  = $urandom_range(0, 4);
            g  = $urandom_range(0, 3);
            lp = ($urandom_range(0, 3) == 0);
            hm = $urandom_range(0, 1);
            if (lp) ab = $urandom_range(2, 30);
            else    ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
            run_campaign($sformatf("rnd%0d", i), s, e, d, g, lp, hm, ab, 1'b1);
            idle_check($sformatf("rnd%0d.idle", i), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
